// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Takes symbolic MIPS instructions over a valid/ready handshake. Each one is
//   assembled into a 32-bit instruction word and written to consecutive
//   instruction-memory addresses. Programs loaded this way are later run by
//   the decode path.
//
// Parameters
//   ADDR_W     instruction-memory word-address width (DEPTH = 2**ADDR_W)
//   BASE_ADDR  first word address written after start_in
//
// Ports
//   clk_in, rst_n_in        clock (rising edge), async active-low reset
//   start_in                begin/restart a load; clears address and count
//   valid_in / ready_out    instruction handshake
//   mnem_in                 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT,
//                           6 LW, 7 SW, 8 ADDI, 9 BEQ, 10 J, 11-15 illegal
//   rs_in, rt_in, rd_in     register fields
//   imm_in, target_in       I-type immediate, J-type target
//   last_in                 final instruction of the program
//   imem_we_out             one-cycle write strobe
//   imem_addr_out/data_out  write address / encoded word (held between writes)
//   count_out               instructions written since start
//   done_out, err_out       level status flags, cleared by the next start
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [3:0]        mnem_in,
  input  logic [4:0]        rs_in,
  input  logic [4:0]        rt_in,
  input  logic [4:0]        rd_in,
  input  logic [15:0]       imm_in,
  input  logic [25:0]       target_in,
  input  logic              last_in,
  output logic              imem_we_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  output logic [31:0]       imem_data_out,
  output logic [ADDR_W:0]   count_out,
  output logic              done_out,
  output logic              err_out
);

  localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  typedef enum logic [3:0] {
    M_NOP  = 4'd0,
    M_ADD  = 4'd1,
    M_SUB  = 4'd2,
    M_AND  = 4'd3,
    M_OR   = 4'd4,
    M_SLT  = 4'd5,
    M_LW   = 4'd6,
    M_SW   = 4'd7,
    M_ADDI = 4'd8,
    M_BEQ  = 4'd9,
    M_J    = 4'd10
  } mnem_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              last_q;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              clr_cnt;
  logic              adv_cnt;
  logic              capture;

  // Instruction assembler; fields a format does not use are dropped here.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (mnem_in)
      M_NOP:   enc_word = '0;
      M_ADD:   enc_word = {6'b000000, rs_in, rt_in, rd_in, 5'b00000, 6'b100000};
      M_SUB:   enc_word = {6'b000000, rs_in, rt_in, rd_in, 5'b00000, 6'b100010};
      M_AND:   enc_word = {6'b000000, rs_in, rt_in, rd_in, 5'b00000, 6'b100100};
      M_OR:    enc_word = {6'b000000, rs_in, rt_in, rd_in, 5'b00000, 6'b100101};
      M_SLT:   enc_word = {6'b000000, rs_in, rt_in, rd_in, 5'b00000, 6'b101010};
      M_LW:    enc_word = {6'b100011, rs_in, rt_in, imm_in};
      M_SW:    enc_word = {6'b101011, rs_in, rt_in, imm_in};
      M_ADDI:  enc_word = {6'b001000, rs_in, rt_in, imm_in};
      M_BEQ:   enc_word = {6'b000100, rs_in, rt_in, imm_in};
      M_J:     enc_word = {6'b000010, target_in};
      default: enc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr_cnt    = 1'b0;
    adv_cnt    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_in) begin
          state_next = LOAD;
          clr_cnt    = 1'b1;
        end
      end
      LOAD: begin
        // start_in aborts any handshake offered in the same cycle.
        if (start_in) begin
          clr_cnt = 1'b1;
        end else if (valid_in) begin
          if (!enc_legal || count == DEPTH_CNT) begin
            state_next = ERR;
          end else begin
            capture    = 1'b1;
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        // The strobe is already out; a restart only redirects the next state.
        if (start_in) begin
          clr_cnt    = 1'b1;
          state_next = LOAD;
        end else begin
          adv_cnt    = 1'b1;
          state_next = last_q ? DONE : LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr    <= BASE;
      count   <= '0;
      data_q  <= '0;
      waddr_q <= '0;
      last_q  <= 1'b0;
    end else begin
      if (clr_cnt) begin
        addr  <= BASE;
        count <= '0;
      end else if (adv_cnt) begin
        addr  <= addr + ADDR_ONE;
        count <= count + CNT_ONE;
      end
      if (capture) begin
        data_q  <= enc_word;
        waddr_q <= addr;
        last_q  <= last_in;
      end
    end
  end

  // Status outputs decode straight from the state so an async reset clears them at once.
  assign ready_out     = (state == LOAD);
  assign imem_we_out   = (state == WRITE);
  assign done_out      = (state == DONE);
  assign err_out       = (state == ERR);
  assign imem_addr_out = waddr_q;
  assign imem_data_out = data_q;
  assign count_out     = count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        valid;
  logic [3:0]  mnem;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] tgt;
  logic        last;

  logic        ready;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [8:0]  count;
  logic        done;
  logic        err;

  logic        s_ready;
  logic        s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  logic [2:0]  s_count;
  logic        s_done;
  logic        s_err;

  int n_assert = 0;
  int n_fail   = 0;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .valid_in(valid),
    .ready_out(ready), .mnem_in(mnem), .rs_in(rs), .rt_in(rt), .rd_in(rd),
    .imm_in(imm), .target_in(tgt), .last_in(last), .imem_we_out(we),
    .imem_addr_out(addr), .imem_data_out(data), .count_out(count),
    .done_out(done), .err_out(err)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .valid_in(valid),
    .ready_out(s_ready), .mnem_in(mnem), .rs_in(rs), .rt_in(rt), .rd_in(rd),
    .imm_in(imm), .target_in(tgt), .last_in(last), .imem_we_out(s_we),
    .imem_addr_out(s_addr), .imem_data_out(s_data), .count_out(s_count),
    .done_out(s_done), .err_out(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One handshake on the 8-bit instance: checks the write cycle and the cycle after.
  task automatic send(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                      input logic lst, input logic [7:0] ea, input logic [31:0] ed,
                      input logic [8:0] ecnt);
    mnem = m; rs = s; rt = t; rd = d; imm = im; tgt = tg; last = lst;
    valid = 1'b1;
    tick();
    chk("we_pulse", 64'(we), 64'(1));
    chk("wr_addr", 64'(addr), 64'(ea));
    chk("wr_data", 64'(data), 64'(ed));
    chk("ready_in_write", 64'(ready), 64'(0));
    tick();
    chk("we_single", 64'(we), 64'(0));
    chk("data_hold", 64'(data), 64'(ed));
    chk("count", 64'(count), 64'(ecnt));
    chk("ready_after", 64'(ready), 64'(!lst));
    chk("done_after", 64'(done), 64'(lst));
  endtask

  initial begin
    logic [4:0] r5;
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
    mnem = '0; rs = '0; rt = '0; rd = '0; imm = '0; tgt = '0;
    #12;
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_s_count", 64'(s_count), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 64'(ready), 64'(0));

    // Single R-type write; imm is garbage and must be ignored.
    do_start();
    chk("load_ready", 64'(ready), 64'(1));
    chk("load_count0", 64'(count), 64'(0));
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h3FFFFFF, 1'b0, 8'd0, 32'h00221820, 9'd1);
    valid = 1'b0;

    // Asynchronous reset while the write strobe is up.
    mnem = 4'd1; valid = 1'b1;
    tick();
    chk("pre_rst_we", 64'(we), 64'(1));
    chk("pre_rst_addr", 64'(addr), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", 64'(we), 64'(0));
    chk("arst_ready", 64'(ready), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("arst_idle_ready", 64'(ready), 64'(0));
    chk("arst_idle_we", 64'(we), 64'(0));

    // I/J program, valid held high back to back; rd is junk on I-type.
    do_start();
    send(4'd6, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h0, 1'b0, 8'd0, 32'h8FA80004, 9'd1);
    send(4'd7, 5'd29, 5'd8, 5'd31, 16'h0008, 26'h0, 1'b0, 8'd1, 32'hAFA80008, 9'd2);
    send(4'd9, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h0, 1'b0, 8'd2, 32'h1022FFFF, 9'd3);
    send(4'd8, 5'd0, 5'd9, 5'd31, 16'h0005, 26'h0, 1'b0, 8'd3, 32'h20090005, 9'd4);
    send(4'd10, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h40, 1'b1, 8'd4, 32'h08000040, 9'd5);
    tick();
    chk("done_hold", 64'(done), 64'(1));
    chk("done_no_we", 64'(we), 64'(0));
    chk("done_count", 64'(count), 64'(5));
    valid = 1'b0;

    // Remaining R-type funcs plus NOP; restart from DONE.
    do_start();
    chk("restart_done_clr", 64'(done), 64'(0));
    chk("restart_count", 64'(count), 64'(0));
    send(4'd0, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h3FFFFFF, 1'b0, 8'd0, 32'h00000000, 9'd1);
    send(4'd2, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h0, 1'b0, 8'd1, 32'h00853022, 9'd2);
    send(4'd3, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h0, 1'b0, 8'd2, 32'h00853024, 9'd3);
    send(4'd4, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h0, 1'b0, 8'd3, 32'h00853025, 9'd4);
    send(4'd5, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h0, 1'b1, 8'd4, 32'h0085302A, 9'd5);
    valid = 1'b0;

    // Illegal mnemonic 12.
    do_start();
    mnem = 4'd12; last = 1'b0; valid = 1'b1;
    tick();
    chk("ill12_err", 64'(err), 64'(1));
    chk("ill12_we", 64'(we), 64'(0));
    chk("ill12_ready", 64'(ready), 64'(0));
    tick();
    chk("ill12_err_hold", 64'(err), 64'(1));
    chk("ill12_we_hold", 64'(we), 64'(0));
    valid = 1'b0;
    do_start();
    chk("err_clr", 64'(err), 64'(0));
    chk("err_clr_ready", 64'(ready), 64'(1));
    send(4'd8, 5'd0, 5'd9, 5'd0, 16'h0005, 26'h0, 1'b0, 8'd0, 32'h20090005, 9'd1);

    // Lowest illegal code 11.
    mnem = 4'd11; valid = 1'b1;
    tick();
    chk("ill11_err", 64'(err), 64'(1));
    chk("ill11_we", 64'(we), 64'(0));
    valid = 1'b0;

    // start_in coinciding with a handshake in LOAD.
    do_start();
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 8'd0, 32'h00221820, 9'd1);
    mnem = 4'd2; valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; valid = 1'b0;
    chk("abort_we", 64'(we), 64'(0));
    chk("abort_count", 64'(count), 64'(0));
    chk("abort_ready", 64'(ready), 64'(1));
    tick();
    chk("abort_we_late", 64'(we), 64'(0));
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 8'd0, 32'h00221820, 9'd1);
    valid = 1'b0;

    // Overflow on the 4-word instance.
    do_start();
    chk("s_ready", 64'(s_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      r5 = 5'(i);
      mnem = 4'd8; rs = 5'd0; rt = r5; imm = 16'(i); last = 1'b0; valid = 1'b1;
      tick();
      chk("s_we", 64'(s_we), 64'(1));
      chk("s_addr", 64'(s_addr), 64'(i));
      chk("s_data", 64'(s_data), 64'({6'b001000, 5'd0, r5, 16'(i)}));
      tick();
      chk("s_we_off", 64'(s_we), 64'(0));
      chk("s_count", 64'(s_count), 64'(i + 1));
    end
    tick();
    chk("s_ovf_err", 64'(s_err), 64'(1));
    chk("s_ovf_we", 64'(s_we), 64'(0));
    chk("s_ovf_ready", 64'(s_ready), 64'(0));
    tick();
    chk("s_ovf_we_hold", 64'(s_we), 64'(0));
    chk("s_ovf_count", 64'(s_count), 64'(4));
    chk("s_ovf_done", 64'(s_done), 64'(0));
    valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
